// File: rtl/gps_ack_search_if.sv
// Search-controller bus between gps_ack_search and its host/correlator.
// The master side drives the start request and correlator magnitude; the slave side (the controller) drives the rest.
interface gps_ack_search_if;
    logic        start;
    logic [5:0]  sat_in;
    logic [15:0] threshold;
    logic [15:0] integrator;
    logic [5:0]  ack_satelite;
    logic [9:0]  ack_chip_delay;
    logic [31:0] ack_doppler;
    logic        ack_clr;
    logic        busy;
    logic        done;
    logic        found;
    logic [9:0]  best_chip;
    logic [4:0]  best_bin;
    logic [15:0] best_mag;

    modport master (
        output start, sat_in, threshold, integrator,
        input  ack_satelite, ack_chip_delay, ack_doppler, ack_clr,
        input  busy, done, found, best_chip, best_bin, best_mag
    );

    modport slave (
        input  start, sat_in, threshold, integrator,
        output ack_satelite, ack_chip_delay, ack_doppler, ack_clr,
        output busy, done, found, best_chip, best_bin, best_mag
    );
endinterface

// File: rtl/gps_ack_search.sv
// Code-phase x Doppler peak search around gps_ack; start->done takes N_CHIPS*N_DOPP_BINS*(DWELL_CYCLES+2)+2 cycles.
// No backpressure: start is ignored while busy. `define GPS_ACK_SEARCH_EARLY_EXIT_EN stops at the first cell >= threshold.
module gps_ack_search #(
    parameter int          DWELL_CYCLES = 16368,
    parameter int          N_CHIPS      = 1023,
    parameter int          N_DOPP_BINS  = 21,
    parameter logic [31:0] DOPP_START   = 32'hFFFF_EC78,
    parameter logic [31:0] DOPP_STEP    = 32'd500
) (
    input  logic             i_clk,
    input  logic             i_rst,
    gps_ack_search_if.slave  io_srch
);

    localparam int             DW         = $clog2(DWELL_CYCLES + 1);
    localparam logic [DW-1:0]  DWELL_LAST = DW'(DWELL_CYCLES - 1);
    localparam logic [9:0]     CHIP_LAST  = 10'(N_CHIPS - 1);
    localparam logic [4:0]     BIN_LAST   = 5'(N_DOPP_BINS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_DWELL,
        S_SAMPLE,
        S_FIN
    } state_t;

    state_t         r_state;
    state_t         w_next;
    logic [5:0]     r_sat;
    logic [15:0]    r_thr;
    logic [9:0]     r_chip;
    logic [4:0]     r_bin;
    logic [31:0]    r_dopp;
    logic [DW-1:0]  r_dwell;
    logic [9:0]     r_best_chip;
    logic [4:0]     r_best_bin;
    logic [15:0]    r_best_mag;
    logic           r_busy;
    logic           r_done;
    logic           r_found;
    logic           w_ack_clr;
    logic           w_sat_ok;
    logic           w_last_cell;
    logic           w_dwell_end;
    logic           w_better;
    logic           w_hit;

    assign w_sat_ok    = (io_srch.sat_in != 6'd0) && (io_srch.sat_in <= 6'd32);
    assign w_last_cell = (r_chip == CHIP_LAST) && (r_bin == BIN_LAST);
    assign w_dwell_end = (r_dwell == DWELL_LAST);
    assign w_better    = (io_srch.integrator > r_best_mag);

`ifdef GPS_ACK_SEARCH_EARLY_EXIT_EN
    assign w_hit = (io_srch.integrator >= r_thr);
`else
    assign w_hit = 1'b0;
`endif

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next    = r_state;
        w_ack_clr = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (io_srch.start && w_sat_ok) begin
                    w_next = S_SETUP;
                end
            end
            S_SETUP: begin
                w_ack_clr = 1'b1;
                w_next    = S_DWELL;
            end
            S_DWELL: begin
                if (w_dwell_end) begin
                    w_next = S_SAMPLE;
                end
            end
            S_SAMPLE: begin
                w_next = (w_last_cell || w_hit) ? S_FIN : S_SETUP;
            end
            S_FIN: begin
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_sat       <= '0;
            r_thr       <= '0;
            r_chip      <= '0;
            r_bin       <= '0;
            r_dopp      <= '0;
            r_dwell     <= '0;
            r_best_chip <= '0;
            r_best_bin  <= '0;
            r_best_mag  <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_found     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (io_srch.start) begin
                        r_best_chip <= '0;
                        r_best_bin  <= '0;
                        r_best_mag  <= '0;
                        r_found     <= 1'b0;
                        if (w_sat_ok) begin
                            r_sat  <= io_srch.sat_in;
                            r_thr  <= io_srch.threshold;
                            r_chip <= '0;
                            r_bin  <= '0;
                            r_dopp <= DOPP_START;
                            r_busy <= 1'b1;
                        end else begin
                            // Invalid PRN: report an empty search straight away.
                            r_done <= 1'b1;
                        end
                    end
                end
                S_SETUP: begin
                    r_dwell <= '0;
                end
                S_DWELL: begin
                    r_dwell <= r_dwell + DW'(1);
                end
                S_SAMPLE: begin
                    if (w_hit || w_better) begin
                        r_best_chip <= r_chip;
                        r_best_bin  <= r_bin;
                        r_best_mag  <= io_srch.integrator;
                    end
                    // Hold the final cell on the ack_* outputs when leaving for FIN.
                    if (!(w_last_cell || w_hit)) begin
                        if (r_chip < CHIP_LAST) begin
                            r_chip <= r_chip + 10'd1;
                        end else begin
                            r_chip <= '0;
                            r_bin  <= r_bin + 5'd1;
                            r_dopp <= r_dopp + DOPP_STEP;
                        end
                    end
                end
                S_FIN: begin
                    r_found <= (r_best_mag >= r_thr);
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_sat   <= '0;
                end
                default: begin
                    r_busy <= 1'b0;
                end
            endcase
        end
    end

    assign io_srch.ack_satelite   = r_sat;
    assign io_srch.ack_chip_delay = r_chip;
    assign io_srch.ack_doppler    = r_dopp;
    assign io_srch.ack_clr        = w_ack_clr;
    assign io_srch.busy           = r_busy;
    assign io_srch.done           = r_done;
    assign io_srch.found          = r_found;
    assign io_srch.best_chip      = r_best_chip;
    assign io_srch.best_bin       = r_best_bin;
    assign io_srch.best_mag       = r_best_mag;

endmodule

// File: tb/tb_gps_ack_search.sv
// Bench for gps_ack_search: a cell-magnitude table stands in for gps_ack, and a list-scan model predicts each search.
module tb_gps_ack_search;
    localparam int D     = 4;
    localparam int NC    = 8;
    localparam int NB    = 3;
    localparam int NCELL = NC * NB;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    gps_ack_search_if bus ();
    gps_ack_search_if bus2 ();

    gps_ack_search #(
        .DWELL_CYCLES(D), .N_CHIPS(NC), .N_DOPP_BINS(NB),
        .DOPP_START(32'd100), .DOPP_STEP(32'd10)
    ) dut (.i_clk(clk), .i_rst(rst), .io_srch(bus));

    gps_ack_search #(
        .DWELL_CYCLES(D), .N_CHIPS(NC), .N_DOPP_BINS(NB),
        .DOPP_START(32'hFFFF_FFFC), .DOPP_STEP(32'd10)
    ) dut2 (.i_clk(clk), .i_rst(rst), .io_srch(bus2));

    logic [15:0] mags [NCELL];
    logic [31:0] w_bin;
    int vectors = 0;
    int miscompares = 0;

    // Correlator stand-in: magnitude of the cell currently selected by the controller.
    assign w_bin = (bus.ack_doppler - 32'd100) / 32'd10;
    always_comb begin
        bus.integrator = 16'd0;
        if (w_bin < 32'(NB) && bus.ack_chip_delay < 10'(NC))
            bus.integrator = mags[int'(w_bin) * NC + int'(bus.ack_chip_delay)];
    end
    assign bus2.integrator = 16'd0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Scan cells in sweep order (chip fastest); first strict maximum wins.
    task automatic model(input logic [15:0] thr, output int ecell, output int emag,
                         output bit efound, output int ncells);
        ecell  = 0;
        emag   = 0;
        ncells = NCELL;
        for (int c = 0; c < NCELL; c++) begin
`ifdef GPS_ACK_SEARCH_EARLY_EXIT_EN
            if (mags[c] >= thr) begin
                ecell  = c;
                emag   = int'(mags[c]);
                ncells = c + 1;
                break;
            end
`endif
            if (int'(mags[c]) > emag) begin
                ecell = c;
                emag  = int'(mags[c]);
            end
        end
        efound = (emag >= int'(thr));
    endtask

    task automatic pulse_start(input logic [5:0] sat, input logic [15:0] thr);
        bus.sat_in    = sat;
        bus.threshold = thr;
        bus.start     = 1'b1;
        @(negedge clk);
        bus.start     = 1'b0;
    endtask

    task automatic sweep(input logic [5:0] sat, input logic [15:0] thr, input bit poke);
        int ecell, emag, ncells, t, k;
        bit efound;
        model(thr, ecell, emag, efound, ncells);
        pulse_start(sat, thr);
        t = 1;
        k = 0;
        while (t < 2000 && !bus.done) begin
            if (poke && t == 40) begin
                bus.sat_in    = 6'd9;
                bus.threshold = 16'd0;
                bus.start     = 1'b1;
            end else begin
                bus.start = 1'b0;
            end
            chk("busy_during", bus.busy, 1);
            if (bus.ack_clr) begin
                chk("cell_chip", bus.ack_chip_delay, k % NC);
                chk("cell_dopp", bus.ack_doppler, 100 + 10 * (k / NC));
                chk("cell_sat", bus.ack_satelite, sat);
                k++;
            end
            @(negedge clk);
            t++;
        end
        bus.start = 1'b0;
        chk("latency", t, ncells * (D + 2) + 2);
        chk("clr_count", k, ncells);
        chk("found", bus.found, efound);
        chk("best_chip", bus.best_chip, ecell % NC);
        chk("best_bin", bus.best_bin, ecell / NC);
        chk("best_mag", bus.best_mag, emag);
        chk("busy_at_done", bus.busy, 0);
        chk("sat_at_done", bus.ack_satelite, 0);
        @(negedge clk);
        chk("done_one_cycle", bus.done, 0);
        chk("found_held", bus.found, efound);
    endtask

    task automatic bad_sat(input logic [5:0] sat);
        pulse_start(sat, 16'd0);
        chk("bad_done", bus.done, 1);
        chk("bad_found", bus.found, 0);
        chk("bad_busy", bus.busy, 0);
        chk("bad_clr", bus.ack_clr, 0);
        chk("bad_best_mag", bus.best_mag, 0);
        chk("bad_best_chip", bus.best_chip, 0);
        @(negedge clk);
        chk("bad_done_drop", bus.done, 0);
        chk("bad_busy_after", bus.busy, 0);
        chk("bad_clr_after", bus.ack_clr, 0);
    endtask

    task automatic all_zero(input string tag);
        chk({tag, "_busy"}, bus.busy, 0);
        chk({tag, "_done"}, bus.done, 0);
        chk({tag, "_found"}, bus.found, 0);
        chk({tag, "_clr"}, bus.ack_clr, 0);
        chk({tag, "_sat"}, bus.ack_satelite, 0);
        chk({tag, "_chip"}, bus.ack_chip_delay, 0);
        chk({tag, "_dopp"}, bus.ack_doppler, 0);
        chk({tag, "_bchip"}, bus.best_chip, 0);
        chk({tag, "_bbin"}, bus.best_bin, 0);
        chk({tag, "_bmag"}, bus.best_mag, 0);
    endtask

    initial begin
        int k, t, seen;
        rst            = 1'b1;
        bus.start      = 1'b0;
        bus.sat_in     = 6'd0;
        bus.threshold  = 16'd0;
        bus2.start     = 1'b0;
        bus2.sat_in    = 6'd0;
        bus2.threshold = 16'd0;
        foreach (mags[i]) mags[i] = 16'd7;
        repeat (3) @(negedge clk);
        all_zero("reset");
        chk("reset_dut2_dopp", bus2.ack_doppler, 0);
        rst = 1'b0;
        @(negedge clk);

        // Single peak at chip 3 / bin 1.
        mags[11] = 16'd60;
        sweep(6'd5, 16'd50, 1'b0);
        sweep(6'd5, 16'd61, 1'b0);

        // Equal peaks: the earlier cell must be kept.
        foreach (mags[i]) mags[i] = 16'd5;
        mags[2]  = 16'd40;
        mags[22] = 16'd40;
        sweep(6'd12, 16'd100, 1'b0);

        // Zero threshold always reports a detection.
        foreach (mags[i]) mags[i] = 16'($urandom_range(0, 255));
        sweep(6'd1, 16'd0, 1'b0);

        for (int r = 0; r < 4; r++) begin
            foreach (mags[i]) mags[i] = 16'($urandom_range(0, 255));
            sweep(6'($urandom_range(1, 32)), 16'($urandom_range(0, 300)), 1'b0);
        end

        bad_sat(6'd0);
        bad_sat(6'd33);

        // Reset during the first dwell aborts silently.
        pulse_start(6'd5, 16'd50);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        all_zero("midrst");
        rst  = 1'b0;
        seen = 0;
        repeat (10) begin
            @(negedge clk);
            if (bus.done || bus.ack_clr || bus.busy) seen++;
        end
        chk("midrst_quiet", seen, 0);

        // Clean sweep with a stray start while busy.
        foreach (mags[i]) mags[i] = 16'($urandom_range(0, 255));
        sweep(6'd5, 16'd1000, 1'b1);

        // Doppler word wraps through zero between bins.
        bus2.sat_in    = 6'd1;
        bus2.threshold = 16'hFFFF;
        bus2.start     = 1'b1;
        @(negedge clk);
        bus2.start = 1'b0;
        k = 0;
        t = 0;
        while (t < 400 && k < 9) begin
            if (bus2.ack_clr) begin
                if (k == 0) chk("wrap_bin0", bus2.ack_doppler, 32'hFFFF_FFFC);
                if (k == 8) chk("wrap_bin1", bus2.ack_doppler, 32'd6);
                k++;
            end
            @(negedge clk);
            t++;
        end
        chk("wrap_clr_seen", k, 9);
        while (t < 400 && !bus2.done) begin
            @(negedge clk);
            t++;
        end
        chk("wrap_done", bus2.done, 1);
        chk("wrap_found", bus2.found, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
